interconnect_arbiter: RTL
=========================

# interconnect_arbiter

Two-master, one-target arbiter for the native valid/ready memory bus used in the interconnect subsystem. It lets a second requester (debug/DMA host) share the peripheral target path with the CPU host. Round-robin grant is held for one complete transaction. An optional watchdog completes stalled transactions with an error word. It sits between the host ports and the address decoder in `interconnect_subsys_top`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 256: BUSY cycles without `tgt_ready` before forced completion. Range 2..65535. Used only with the timeout macro.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on a timed-out transaction.

Ports:
- `sys_clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `m0_valid` / `m1_valid` in 1: master request. Held high until that master's ready.
- `m0_addr` / `m1_addr` in 31: byte address.
- `m0_write` / `m1_write` in 1: 1 = write.
- `m0_wdata` / `m1_wdata` in 32: write data.
- `m0_wstrb` / `m1_wstrb` in 4: byte strobes.
- `m0_rdata` / `m1_rdata` out 32: read data.
- `m0_ready` / `m1_ready` out 1: one-cycle completion pulse.
- `tgt_valid` out 1: request to the target.
- `tgt_addr` out 31, `tgt_write` out 1, `tgt_wdata` out 32, `tgt_wstrb` out 4: the granted master's request fields.
- `tgt_rdata` in 32: target read data.
- `tgt_ready` in 1: target completion.
- `timeout_err` out 1: sticky timeout flag.
- `err_clr` in 1: clears `timeout_err`.

## Operation
- State machine with two states:
  - IDLE: no grant held.
  - BUSY: grant held.
- IDLE:
  - If any `mX_valid` is high, register `grant` (1 bit) and go to BUSY.
  - If only one master is requesting, it wins.
  - If both are requesting, the master other than `last_grant` wins.
- BUSY:
  - `tgt_valid` = 1.
  - `tgt_addr`, `tgt_write`, `tgt_wdata`, `tgt_wstrb` are combinationally muxed from the granted master.
  - The granted `mX_ready` = `tgt_ready`, combinationally. The other master's ready = 0.
  - On `tgt_ready`: go to IDLE and set `last_grant <= grant`.
- `m0_rdata` = `m1_rdata` = `tgt_rdata` (broadcast). The exception is the timeout completion cycle, where both equal `ERR_DATA`.
- In IDLE, `tgt_valid` = 0 and all `tgt_*` request fields drive 0.
- A master that drops `valid` while BUSY breaks the protocol. The arbiter does not check for this and still waits for `tgt_ready`.
- Simultaneous `tgt_ready` and timeout expiry: `tgt_ready` wins, no error is raised, and the target data is returned.
- `err_clr` in the same cycle as a new timeout: the set wins.
- Reset at any time, including mid-transaction:
  - State returns to IDLE; `tgt_valid`, both readies and `timeout_err` go to 0.
  - `last_grant` resets to 1, so m0 wins the first contention.
  - The in-flight transaction is dropped.
- Reset value of `mX_rdata` follows `tgt_rdata`; it is not registered.

## Timing
- Master `valid` rises in cycle N (IDLE) → `tgt_valid` = 1 in N+1.
- `tgt_ready` in cycle N+k → `mX_ready` in N+k, with 0 added latency.
- IDLE in N+k+1. The next grant is registered at the end of N+k+1, so the next `tgt_valid` is in N+k+2.
- This gives one mandatory bubble cycle between back-to-back transactions.
- Minimum transaction, with a target that is ready in its first valid cycle: 2 cycles from valid to ready.
- `timeout_err` rises the cycle after the forced completion.

## Configuration
- Macro: `INTERCONNECT_ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without `tgt_ready`.
  - In the cycle the counter equals `TIMEOUT_CYCLES-1` and `tgt_ready` = 0:
    - the granted `mX_ready` = 1 and both rdata outputs = `ERR_DATA`;
    - the state returns to IDLE, so `tgt_valid` drops the next cycle;
    - `timeout_err` is set.
  - A late `tgt_ready` while IDLE is ignored.
- Undefined:
  - No counter; BUSY waits indefinitely.
  - `timeout_err` is tied to 0 and `err_clr` is unused.

## Structure
- `interconnect_pkg` holds:
  - the `arb_state_e` enum (IDLE, BUSY);
  - the `host_req_t` struct (valid, addr, write, wdata, wstrb);
  - the `DEFAULT_ERR_DATA` constant.
- Sub-module `interconnect_rr_pick`: a combinational two-way round-robin selector. Inputs are `req[1:0]` and `last_grant`; outputs are `gnt` and `any`.
- All other logic lives in `interconnect_arbiter`.

## Test plan
- Single m0 read; target ready on its 3rd valid cycle with `tgt_rdata` = 32'h1234_5678 → `m0_ready` pulses in that cycle with `m0_rdata` = 32'h1234_5678; `m1_ready` stays 0.
- Both masters raise valid in the same cycle after reset → m0 is granted first. m1 is granted after one bubble, with `tgt_valid` rising 1 cycle after IDLE.
- Both masters request continuously for 6 transactions → grants alternate m0, m1, m0, m1, m0, m1.
- m1 write with addr 31'h0000_0040, wstrb 4'b0011 → `tgt_addr`, `tgt_wstrb` and `tgt_wdata` exactly match m1's fields while BUSY.
- With the macro defined and `TIMEOUT_CYCLES` = 8, target never ready → master ready in BUSY cycle 8 with rdata 32'hDEAD_BEEF; `timeout_err` = 1 the next cycle; `err_clr` clears it.
- Assert `rst_n` = 0 mid-BUSY → `tgt_valid` and readies go to 0 immediately. After release, both-valid grants m0.

Source files
------------

// File: rtl/interconnect_pkg.sv
// interconnect_pkg
//   Shared types and constants for the interconnect host-port arbiter.
//   - arb_state_e      : arbiter FSM states (IDLE, BUSY)
//   - host_req_t       : one master's request bundle on the native bus
//   - DEFAULT_ERR_DATA : read data returned when a transaction is forced closed
package interconnect_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic        valid;
    logic [30:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } host_req_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/interconnect_rr_pick.sv
// interconnect_rr_pick
//   Combinational two-way round-robin selector.
//   Ports:
//     req[1:0]   in  : request lines, bit 0 = m0, bit 1 = m1
//     last_grant in  : master that owned the previous transaction
//     gnt        out : selected master (0 = m0, 1 = m1), valid when any = 1
//     any        out : at least one request present
module interconnect_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt,
  output logic       any
);

  always_comb begin
    any = |req;
    gnt = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      // Contention: the master that did not go last wins.
      2'b11:   gnt = ~last_grant;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/interconnect_arbiter.sv
// interconnect_arbiter
//   Two-master, one-target arbiter for the native valid/ready memory bus.
//   Round-robin grant, held for one complete transaction; one bubble cycle
//   between back-to-back transactions.
//   Optional feature macro: INTERCONNECT_ARB_TIMEOUT_EN
//     defined   -> watchdog forces completion with ERR_DATA after
//                  TIMEOUT_CYCLES stalled BUSY cycles and sets timeout_err
//     undefined -> no watchdog, timeout_err tied 0, err_clr unused
//   Ports:
//     sys_clk, rst_n               : clock (rising edge), async active-low reset
//     m0_*/m1_* valid,addr,write,
//       wdata,wstrb  (in)          : master requests
//     m0_rdata/m1_rdata (out)      : broadcast read data
//     m0_ready/m1_ready (out)      : one-cycle completion pulse to owner
//     tgt_valid,addr,write,wdata,
//       wstrb (out)                : granted request toward the target
//     tgt_rdata, tgt_ready (in)    : target response
//     timeout_err (out), err_clr (in) : sticky watchdog flag and its clear
module interconnect_arbiter
  import interconnect_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        m0_valid,
  input  logic [30:0] m0_addr,
  input  logic        m0_write,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [30:0] m1_addr,
  input  logic        m1_write,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        tgt_valid,
  output logic [30:0] tgt_addr,
  output logic        tgt_write,
  output logic [31:0] tgt_wdata,
  output logic [3:0]  tgt_wstrb,
  input  logic [31:0] tgt_rdata,
  input  logic        tgt_ready,
  output logic        timeout_err,
  input  logic        err_clr
);

  host_req_t  req0, req1;
  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic       pick_gnt, pick_any;
  logic       timeout_hit;
  logic       done;

  assign req0 = '{valid: m0_valid, addr: m0_addr, write: m0_write,
                  wdata: m0_wdata, wstrb: m0_wstrb};
  assign req1 = '{valid: m1_valid, addr: m1_addr, write: m1_write,
                  wdata: m1_wdata, wstrb: m1_wstrb};

  interconnect_rr_pick u_pick (
    .req        ({req1.valid, req0.valid}),
    .last_grant (last_grant_q),
    .gnt        (pick_gnt),
    .any        (pick_any)
  );

`ifdef INTERCONNECT_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_q;
  logic        timeout_err_q;

  // tgt_ready in the expiry cycle takes priority, so no forced completion.
  assign timeout_hit = (state_q == BUSY) && !tgt_ready && (tmo_cnt_q == TMO_LAST);

  // Counter sits at 0 throughout IDLE, so it is clear on entry to BUSY.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      tmo_cnt_q <= '0;
    end else if (!tgt_ready) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  // Set has priority over clear.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err_q <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err_q <= 1'b1;
    end else if (err_clr) begin
      timeout_err_q <= 1'b0;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_cfg;

  assign unused_cfg  = err_clr | (TIMEOUT_CYCLES == 0);
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign done = (state_q == BUSY) && (tgt_ready || timeout_hit);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_gnt;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields are forced to zero while no grant is held.
  always_comb begin
    tgt_valid = 1'b0;
    tgt_addr  = '0;
    tgt_write = 1'b0;
    tgt_wdata = '0;
    tgt_wstrb = '0;
    if (state_q == BUSY) begin
      tgt_valid = 1'b1;
      tgt_addr  = grant_q ? req1.addr  : req0.addr;
      tgt_write = grant_q ? req1.write : req0.write;
      tgt_wdata = grant_q ? req1.wdata : req0.wdata;
      tgt_wstrb = grant_q ? req1.wstrb : req0.wstrb;
    end
  end

  assign m0_ready = done && !grant_q;
  assign m1_ready = done &&  grant_q;
  assign m0_rdata = timeout_hit ? ERR_DATA : tgt_rdata;
  assign m1_rdata = timeout_hit ? ERR_DATA : tgt_rdata;

endmodule
